// File: rtl/vend_controller.sv
// Vending transaction controller: accumulates coin credit, checks selections
// against parameterised prices, and sequences the dispense motor and the
// change hopper through req/ack handshakes. All outputs are registered.
`timescale 1ns/1ps
module vend_controller #(
    parameter int PRICE0     = 5,
    parameter int PRICE1     = 7,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15,
    parameter int TIMEOUT    = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_1,
    input  logic                coin_2,
    input  logic                sel_valid,
    input  logic                sel_id,
    input  logic                cancel,
    output logic                vend_req,
    output logic                vend_id,
    input  logic                vend_done,
    output logic                chg_req,
    output logic                chg_2,
    input  logic                chg_ack,
    output logic                coin_reject,
    output logic                sel_deny,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam int SUM_W   = CREDIT_W + 1;

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                vend_id_q, vend_id_d;
    logic                vend_req_q, vend_req_d;
    logic                chg_req_q, chg_req_d;
    logic                chg_2_q, chg_2_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_deny_q, sel_deny_d;
    logic                busy_q, busy_d;

    logic [1:0]          coin_val;
    logic                coin_any;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] sel_price;
    logic                can_buy;

    // Coin value, overflow check against the current credit, and price lookup
    always_comb begin
        coin_val  = {coin_2, coin_1};
        coin_any  = coin_1 | coin_2;
        coin_sum  = SUM_W'(credit_q) + SUM_W'(coin_val);
        coin_fits = (coin_sum <= SUM_W'(MAX_CREDIT));
        sel_price = sel_id ? CREDIT_W'(PRICE1) : CREDIT_W'(PRICE0);
        can_buy   = (credit_q >= sel_price);
    end

    // Next-state, credit, timer and registered-output computation
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        timer_d       = timer_q;
        vend_id_d     = vend_id_q;
        coin_reject_d = 1'b0;
        sel_deny_d    = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (sel_valid) begin
                    sel_deny_d = 1'b1;
                end
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            CREDIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (cancel) begin
                    coin_reject_d = coin_any;
                    state_d       = CHANGE;
                end else if (sel_valid && can_buy) begin
                    timer_d       = '0;
                    credit_d      = credit_q - sel_price
                                    + (coin_fits ? CREDIT_W'(coin_val) : '0);
                    coin_reject_d = coin_any && !coin_fits;
                    vend_id_d     = sel_id;
                    state_d       = VEND;
                end else begin
                    if (sel_valid) begin
                        sel_deny_d = 1'b1;
                        timer_d    = '0;
                    end
                    if (coin_any) begin
                        if (coin_fits) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                            timer_d  = '0;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    if (!sel_valid && !(coin_any && coin_fits)
                        && (timer_q == TIMER_W'(TIMEOUT - 1))) begin
                        state_d = CHANGE;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_any;
                sel_deny_d    = sel_valid;
                if (vend_done) begin
                    state_d = CHANGE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_any;
                if (chg_ack && chg_req_q) begin
                    credit_d = credit_q - (chg_2_q ? CREDIT_W'(2) : CREDIT_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Nothing left to return means the transaction is over
        if ((state_d == CHANGE) && (credit_d == '0)) begin
            state_d = IDLE;
        end

        vend_req_d = (state_d == VEND);
        chg_req_d  = (state_d == CHANGE);
        chg_2_d    = chg_req_d && (credit_d >= CREDIT_W'(2));
        busy_d     = vend_req_d || chg_req_d;
    end

    // State and output registers; reset forfeits credit and drops all requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            timer_q       <= '0;
            vend_id_q     <= 1'b0;
            vend_req_q    <= 1'b0;
            chg_req_q     <= 1'b0;
            chg_2_q       <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_deny_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            timer_q       <= timer_d;
            vend_id_q     <= vend_id_d;
            vend_req_q    <= vend_req_d;
            chg_req_q     <= chg_req_d;
            chg_2_q       <= chg_2_d;
            coin_reject_q <= coin_reject_d;
            sel_deny_q    <= sel_deny_d;
            busy_q        <= busy_d;
        end
    end

    assign vend_req    = vend_req_q;
    assign vend_id     = vend_id_q;
    assign chg_req     = chg_req_q;
    assign chg_2       = chg_2_q;
    assign coin_reject = coin_reject_q;
    assign sel_deny    = sel_deny_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus pushes expected output events,
// an independent monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_vend_controller;

    localparam int CREDIT_W = 4;
    localparam int TIMEOUT  = 200;

    localparam int EV_REJECT = 0;
    localparam int EV_DENY   = 1;
    localparam int EV_VEND   = 2;
    localparam int EV_CHG    = 3;
    localparam int EV_IDLE   = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                coin_1, coin_2, sel_valid, sel_id, cancel;
    logic                vend_done, chg_ack;
    logic                vend_req, vend_id, chg_req, chg_2;
    logic                coin_reject, sel_deny, busy;
    logic [CREDIT_W-1:0] credit;

    typedef struct {
        int   kind;
        logic flag;
        int   cr;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    vend_controller #(
        .PRICE0(5), .PRICE1(7), .CREDIT_W(CREDIT_W), .MAX_CREDIT(15), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_1(coin_1), .coin_2(coin_2),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .vend_req(vend_req), .vend_id(vend_id), .vend_done(vend_done),
        .chg_req(chg_req), .chg_2(chg_2), .chg_ack(chg_ack),
        .coin_reject(coin_reject), .sel_deny(sel_deny),
        .credit(credit), .busy(busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic string kindName(int k);
        case (k)
            EV_REJECT: return "reject";
            EV_DENY:   return "deny";
            EV_VEND:   return "vend";
            EV_CHG:    return "chg";
            EV_IDLE:   return "idle";
            default:   return "unknown";
        endcase
    endfunction

    task automatic expectEvent(input int kind, input logic flag, input int cr);
        exp_t e;
        e.kind = kind;
        e.flag = flag;
        e.cr   = cr;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic scoreEvent(input int kind, input logic flag, input int cr);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_%s: got flag=%0d credit=%0d, expected no event",
                     kindName(kind), flag, cr);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.flag !== flag || e.cr != cr) begin
                miscompares++;
                $display("[TB] FAIL event_%s: got %s flag=%0d credit=%0d, expected %s flag=%0d credit=%0d",
                         kindName(e.kind), kindName(kind), flag, cr,
                         kindName(e.kind), e.flag, e.cr);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and scores them in order
    initial begin
        logic prev_vend, prev_chg, prev_ack, prev_busy;
        prev_vend = 1'b0; prev_chg = 1'b0; prev_ack = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vend = 1'b0; prev_chg = 1'b0; prev_ack = 1'b0; prev_busy = 1'b0;
            end else begin
                if (coin_reject) scoreEvent(EV_REJECT, 1'b0, int'(credit));
                if (sel_deny) scoreEvent(EV_DENY, 1'b0, int'(credit));
                if (vend_req && !prev_vend) scoreEvent(EV_VEND, vend_id, int'(credit));
                if (chg_req && (!prev_chg || prev_ack)) scoreEvent(EV_CHG, chg_2, int'(credit));
                if (!busy && prev_busy) scoreEvent(EV_IDLE, 1'b0, int'(credit));
                prev_vend = vend_req;
                prev_chg  = chg_req;
                prev_ack  = chg_req && chg_ack;
                prev_busy = busy;
            end
        end
    end

    // Hard stop in case something wedges outside a bounded wait
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic c1, input logic c2, input logic sv,
                                 input logic sid, input logic cn);
        coin_1 = c1; coin_2 = c2; sel_valid = sv; sel_id = sid; cancel = cn;
        @(posedge clk);
        #1;
        coin_1 = 1'b0; coin_2 = 1'b0; sel_valid = 1'b0; sel_id = 1'b0; cancel = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseVendDone();
        int n;
        n = 0;
        while (!vend_req && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!vend_req) begin
            checkOutput("vend_req_wait", 0, 1);
        end else begin
            vend_done = 1'b1;
            @(posedge clk); #1;
            vend_done = 1'b0;
        end
    endtask

    task automatic ackChange();
        int n;
        n = 0;
        while (!chg_req && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!chg_req) begin
            checkOutput("chg_req_wait", 0, 1);
        end else begin
            chg_ack = 1'b1;
            @(posedge clk); #1;
            chg_ack = 1'b0;
        end
    endtask

    // Directed stimulus with hand-computed expectations
    initial begin
        int n;
        rst_n = 1'b0;
        coin_1 = 1'b0; coin_2 = 1'b0; sel_valid = 1'b0; sel_id = 1'b0; cancel = 1'b0;
        vend_done = 1'b0; chg_ack = 1'b0;
        idleCycles(3);
        checkOutput("reset_credit", int'(credit), 0);
        checkOutput("reset_vend_req", int'(vend_req), 0);
        checkOutput("reset_chg_req", int'(chg_req), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_pulses", int'({coin_reject, sel_deny, chg_2, vend_id}), 0);
        rst_n = 1'b1;
        idleCycles(2);

        // Selection and cancel in IDLE
        expectEvent(EV_DENY, 1'b0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("idle_cancel_busy", int'(busy), 0);

        // Exact payment for product 0
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("credit_after_1", int'(credit), 1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("credit_5", int'(credit), 5);
        expectEvent(EV_VEND, 1'b0, 0);
        expectEvent(EV_IDLE, 1'b0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("vend0_req", int'(vend_req), 1);
        pulseVendDone();
        idleCycles(2);
        checkOutput("vend0_no_chg", int'(chg_req), 0);

        // Product 1 with one rupee change
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("credit_8", int'(credit), 8);
        expectEvent(EV_VEND, 1'b1, 1);
        expectEvent(EV_CHG, 1'b0, 1);
        expectEvent(EV_IDLE, 1'b0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        pulseVendDone();
        ackChange();
        idleCycles(2);
        checkOutput("vend1_done_chg_req", int'(chg_req), 0);

        // Credit ceiling
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("credit_14", int'(credit), 14);
        expectEvent(EV_REJECT, 1'b0, 14);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("overflow_credit_14", int'(credit), 14);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("credit_15", int'(credit), 15);
        expectEvent(EV_REJECT, 1'b0, 15);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("both_coins_credit_15", int'(credit), 15);

        // Cancel at 15: seven 2-rupee coins then one 1-rupee coin
        for (int c = 15; c >= 3; c -= 2) expectEvent(EV_CHG, 1'b1, c);
        expectEvent(EV_CHG, 1'b0, 1);
        expectEvent(EV_IDLE, 1'b0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) ackChange();
        idleCycles(2);

        // Insufficient credit then cancel
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        expectEvent(EV_DENY, 1'b0, 3);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("deny_credit_3", int'(credit), 3);
        expectEvent(EV_CHG, 1'b1, 3);
        expectEvent(EV_CHG, 1'b0, 1);
        expectEvent(EV_IDLE, 1'b0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        ackChange();
        ackChange();
        idleCycles(2);
        checkOutput("cancel_credit_0", int'(credit), 0);

        // Inactivity refund with a coin inserted mid-refund
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        expectEvent(EV_CHG, 1'b1, 4);
        n = 0;
        while (!chg_req && n < TIMEOUT + 20) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("timeout_cycles", n, TIMEOUT);
        idleCycles(1);
        expectEvent(EV_REJECT, 1'b0, 4);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("chg_coin_credit_4", int'(credit), 4);
        expectEvent(EV_CHG, 1'b1, 2);
        expectEvent(EV_IDLE, 1'b0, 0);
        ackChange();
        ackChange();
        idleCycles(2);

        // Reset during a dispense
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        expectEvent(EV_VEND, 1'b0, 1);
        applyStimulus(0, 0, 1, 0, 0);
        idleCycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_vend_req", int'(vend_req), 0);
        checkOutput("rst_credit", int'(credit), 0);
        checkOutput("rst_busy", int'(busy), 0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(1);
        expectEvent(EV_DENY, 1'b0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("post_rst_vend_req", int'(vend_req), 0);
        idleCycles(3);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
